wb_cmd_responder: RTL and testbench
===================================

Name: wb_cmd_responder

Overview:
Wishbone slave register front-end for the I2C master model: the responder end of the WB initiator/driver traffic.
- Decodes writes and reads to CSR/DPR/CMDR/STATE.
- Turns CMDR writes into byte-level commands for a downstream I2C byte engine.
- Folds engine completions back into CMDR status bits and irq_o.
- Sits between the WB bus and the I2C byte engine inside the DUT model and the reference-model harness.

Parameters:
- NUM_BUSES, 16: number of selectable I2C buses; valid bus ids 0..NUM_BUSES-1 (max 16).
- RESET_BUS_ID, 0: bus id selected out of reset.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- cyc_i  in  1  WB cycle
- stb_i  in  1  WB strobe
- we_i  in  1  WB write enable
- adr_i  in  2  register select: 00 CSR, 01 DPR, 10 CMDR, 11 STATE
- dat_i  in  8  WB write data
- dat_o  out  8  WB read data
- ack_o  out  1  WB acknowledge
- irq_o  out  1  interrupt, level
- cmd_o  out  3  engine command: 100 START, 101 STOP, 001 WRITE, 010 READ_ACK, 011 READ_NACK
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  engine accepts command
- tx_byte_o  out  8  byte for WRITE (DPR contents)
- bus_id_o  out  4  selected bus
- rsp_valid_i  in  1  one-cycle engine completion pulse
- rsp_nak_i  in  1  completion flag: NAK seen
- rsp_al_i  in  1  completion flag: arbitration lost
- rsp_err_i  in  1  completion flag: illegal command for bus state
- rx_byte_i  in  8  read byte, valid with rsp_valid_i on READ_* commands

Behaviour:
Reset: all outputs 0 except bus_id_o=RESET_BUS_ID. Registers: CSR=0, DPR=0, CMDR status=0. State=DISABLED.

WB port:
- ack_o asserts the cycle after cyc_i&stb_i&!ack_o, for exactly 1 cycle.
- Back-to-back transfers yield ack every other cycle.
- Writes commit on the ack cycle; dat_o is registered and valid with ack_o.

Register map:
- CSR: [7] E, [6] IE (both RW); [5] BB (RO, bus busy); [4] BC (RO, busy with command); [3:0] bus id (RO).
- DPR: write sets tx byte; read returns last rx byte.
- CMDR: [7] DON, [6] NAK, [5] AL, [4] ERR (RO); [2:0] last command (reads back the written value).
- STATE: [7:4] FSM state code, [3:0]=0.

FSM state codes: DISABLED=0, IDLE=1, ISSUE=2, WAIT=3, LOCAL=4.
- DISABLED: CMDR writes ignored; goes to IDLE on the cycle after a CSR write with E=1.
- IDLE: a CMDR write clears DON/NAK/AL/ERR and sets BC, then decodes:
  - 110 SET_BUS goes to LOCAL.
  - 000 or 111 sets ERR next cycle, clears BC, stays IDLE.
  - All other codes go to ISSUE.
- ISSUE: cmd_valid_o=1 with cmd_o and tx_byte_o held stable until cmd_ready_i; the handshake cycle moves to WAIT.
- WAIT: on rsp_valid_i:
  - Set DON if no flag, else set the matching NAK/AL/ERR; DON stays 0 when any flag is set.
  - Clear BC.
  - Capture rx_byte_i for READ_*.
  - BB: set on START success; cleared on STOP success or on AL.
  - Return to IDLE.
- LOCAL (1 cycle): if DPR < NUM_BUSES, bus_id_o <= DPR[3:0] and set DON; else set ERR. Then IDLE.
  - SET_BUS while BB=1 sets ERR and leaves the bus unchanged.

Edge cases:
- CMDR write in ISSUE/WAIT/LOCAL: ignored, status unchanged, no second command.
- DPR write during ISSUE: tx_byte_o is not affected (snapshot taken at the CMDR write).
- CSR write with E=0 in any state: go to DISABLED next cycle, drop cmd_valid_o, clear BB/BC/status, ignore a pending rsp_valid_i.
- rsp_valid_i outside WAIT: ignored.
- irq_o = IE & (DON|NAK|AL|ERR), registered. A WB read of CMDR clears all four status bits on the ack cycle and hence clears irq_o the cycle after.
- Simultaneous rsp_valid_i and a CMDR read in WAIT: the new status wins.
- Asynchronous reset mid-transfer: ack_o and cmd_valid_o drop immediately.

Decomposition:
- Reuse from wb_types_pkg: wb_reg_t for address decode, wb_cmd_mon_t for the command field.
- Add to wb_types_pkg:
  - resp_state_t enum with the five state codes above.
  - CSR/CMDR bit-index localparams (CSR_E=7, CSR_IE=6, CSR_BB=5, CSR_BC=4; CMDR_DON=7, CMDR_NAK=6, CMDR_AL=5, CMDR_ERR=4).
- One natural sub-module: wb_slave_port (ack generation, address decode, read mux). The FSM and status logic stay in the top.

Test Plan:
1. Reset, then read all 4 registers -> CSR=0x00, DPR=0x00, CMDR=0x00, STATE=0x00; each ack is 1 cycle, 1 cycle after stb.
2. CSR<=0xC0, DPR<=0x05, CMDR<=0x06 -> no cmd_valid_o; bus_id_o=5; CMDR reads 0x86; irq_o=1, cleared after that CMDR read. With NUM_BUSES=16, DPR<=0x10 then SET_BUS -> CMDR=0x16 (ERR set), bus_id_o unchanged.
3. CMDR<=0x04 with cmd_ready_i held 0 for 3 cycles -> cmd_valid_o high for 4 cycles with cmd_o=100. Then rsp_valid_i with no flags -> CSR BB=1, CMDR=0x84.
4. DPR<=0xA5, CMDR<=0x01, engine responds rsp_nak_i=1 -> tx_byte_o=0xA5 during ISSUE; CMDR=0x41 (NAK set, DON clear).
5. CMDR<=0x02, rx_byte_i=0x3C with rsp_valid_i -> DPR reads 0x3C, CMDR=0x82. A CMDR<=0x01 issued during WAIT is ignored (exactly one cmd_valid_o handshake).
6. CSR<=0x00 during WAIT -> STATE reads 0x00 next; a later rsp_valid_i changes nothing. Async reset asserted mid-ack -> ack_o=0 the same cycle.

Source files
------------

// File: rtl/wb_types_pkg.sv
// Shared Wishbone register-map and command types for the I2C master model.
// Used by the WB command responder and its bus port.
package wb_types_pkg;

  typedef enum logic [1:0] {
    WB_REG_CSR   = 2'b00,
    WB_REG_DPR   = 2'b01,
    WB_REG_CMDR  = 2'b10,
    WB_REG_STATE = 2'b11
  } wb_reg_t;

  typedef enum logic [2:0] {
    CMD_WAIT      = 3'b000,
    CMD_WRITE     = 3'b001,
    CMD_READ_ACK  = 3'b010,
    CMD_READ_NACK = 3'b011,
    CMD_START     = 3'b100,
    CMD_STOP      = 3'b101,
    CMD_SET_BUS   = 3'b110,
    CMD_RSVD      = 3'b111
  } wb_cmd_mon_t;

  typedef enum logic [3:0] {
    ST_DISABLED = 4'd0,
    ST_IDLE     = 4'd1,
    ST_ISSUE    = 4'd2,
    ST_WAIT     = 4'd3,
    ST_LOCAL    = 4'd4
  } resp_state_t;

  localparam int CSR_E    = 7;
  localparam int CSR_IE   = 6;
  localparam int CSR_BB   = 5;
  localparam int CSR_BC   = 4;
  localparam int CMDR_DON = 7;
  localparam int CMDR_NAK = 6;
  localparam int CMDR_AL  = 5;
  localparam int CMDR_ERR = 4;

  function automatic logic is_read_cmd(input wb_cmd_mon_t c);
    return (c == CMD_READ_ACK) || (c == CMD_READ_NACK);
  endfunction

endpackage

// File: rtl/wb_slave_port.sv
// Wishbone slave front end: single-cycle ack, address decode and registered read mux.
// Register side effects are reported as one-cycle strobes on the ack cycle.
module wb_slave_port
  import wb_types_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] csr_rd_i,
  input  logic [7:0] dpr_rd_i,
  input  logic [7:0] cmdr_rd_i,
  input  logic [7:0] state_rd_i,
  output logic       ack_o,
  output logic [7:0] dat_o,
  output logic       wr_csr_o,
  output logic       wr_dpr_o,
  output logic       wr_cmdr_o,
  output logic       rd_cmdr_o
);

  logic       ack_q;
  logic [7:0] dat_q;
  logic       req;
  logic       commit;
  wb_reg_t    reg_sel;
  logic [7:0] rd_mux;

  assign req     = cyc_i & stb_i;
  assign commit  = req & ack_q;
  assign reg_sel = wb_reg_t'(adr_i);

  always_comb begin
    rd_mux = 8'h00;
    case (reg_sel)
      WB_REG_CSR:   rd_mux = csr_rd_i;
      WB_REG_DPR:   rd_mux = dpr_rd_i;
      WB_REG_CMDR:  rd_mux = cmdr_rd_i;
      WB_REG_STATE: rd_mux = state_rd_i;
      default:      rd_mux = 8'h00;
    endcase
  end

  // Read data is sampled in the request cycle so it lines up with ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 8'h00;
    end else begin
      ack_q <= req & ~ack_q;
      dat_q <= (req & ~ack_q & ~we_i) ? rd_mux : 8'h00;
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign wr_csr_o  = commit &  we_i & (reg_sel == WB_REG_CSR);
  assign wr_dpr_o  = commit &  we_i & (reg_sel == WB_REG_DPR);
  assign wr_cmdr_o = commit &  we_i & (reg_sel == WB_REG_CMDR);
  assign rd_cmdr_o = commit & ~we_i & (reg_sel == WB_REG_CMDR);

endmodule

// File: rtl/wb_cmd_responder.sv
// WB register front end of the I2C master: turns CMDR writes into byte-engine
// commands and folds engine completions back into CMDR status and irq_o.
module wb_cmd_responder
  import wb_types_pkg::*;
#(
  parameter int NUM_BUSES    = 16,
  parameter int RESET_BUS_ID = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       irq_o,
  output logic [2:0] cmd_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [7:0] tx_byte_o,
  output logic [3:0] bus_id_o,
  input  logic       rsp_valid_i,
  input  logic       rsp_nak_i,
  input  logic       rsp_al_i,
  input  logic       rsp_err_i,
  input  logic [7:0] rx_byte_i
);

  localparam logic [8:0] NUM_BUSES_W = 9'(NUM_BUSES);

  resp_state_t state_q;
  wb_cmd_mon_t cmd_q, wr_cmd;
  logic        e_q, ie_q, bb_q, bc_q, irq_q, cmd_valid_q;
  logic [3:0]  bus_id_q;
  logic [7:0]  tx_q, tx_snap_q, rx_q;
  logic [2:0]  last_cmd_q;
  logic [7:4]  status_q;
  logic        any_flag;
  logic        wr_csr, wr_dpr, wr_cmdr, rd_cmdr;

  wb_slave_port u_port (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cyc_i      (cyc_i),
    .stb_i      (stb_i),
    .we_i       (we_i),
    .adr_i      (adr_i),
    .csr_rd_i   ({e_q, ie_q, bb_q, bc_q, bus_id_q}),
    .dpr_rd_i   (rx_q),
    .cmdr_rd_i  ({status_q, 1'b0, last_cmd_q}),
    .state_rd_i ({state_q, 4'h0}),
    .ack_o      (ack_o),
    .dat_o      (dat_o),
    .wr_csr_o   (wr_csr),
    .wr_dpr_o   (wr_dpr),
    .wr_cmdr_o  (wr_cmdr),
    .rd_cmdr_o  (rd_cmdr)
  );

  assign wr_cmd   = wb_cmd_mon_t'(dat_i[2:0]);
  assign any_flag = rsp_nak_i | rsp_al_i | rsp_err_i;

  // Engine handshake: cmd_valid_o rises with cmd_o/tx_byte_o already stable and
  // holds them unchanged until a cycle with cmd_ready_i high; that edge transfers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_DISABLED;
      cmd_q       <= CMD_WAIT;
      e_q         <= 1'b0;
      ie_q        <= 1'b0;
      bb_q        <= 1'b0;
      bc_q        <= 1'b0;
      irq_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      bus_id_q    <= 4'(RESET_BUS_ID);
      tx_q        <= 8'h00;
      tx_snap_q   <= 8'h00;
      rx_q        <= 8'h00;
      last_cmd_q  <= 3'b000;
      status_q    <= 4'h0;
    end else begin
      if (wr_dpr) tx_q <= dat_i;
      if (wr_csr) begin
        e_q  <= dat_i[CSR_E];
        ie_q <= dat_i[CSR_IE];
      end
      if (rd_cmdr) status_q <= 4'h0;
      irq_q <= ie_q & (|status_q);

      case (state_q)
        ST_DISABLED: if (wr_csr && dat_i[CSR_E]) state_q <= ST_IDLE;
        ST_IDLE: if (wr_cmdr) begin
          last_cmd_q <= dat_i[2:0];
          status_q   <= 4'h0;
          bc_q       <= 1'b1;
          case (wr_cmd)
            CMD_SET_BUS: state_q <= ST_LOCAL;
            CMD_WAIT, CMD_RSVD: begin
              status_q[CMDR_ERR] <= 1'b1;
              bc_q               <= 1'b0;
            end
            default: begin
              cmd_q       <= wr_cmd;
              tx_snap_q   <= tx_q;
              cmd_valid_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end
          endcase
        end
        ST_ISSUE: if (cmd_ready_i) begin
          cmd_valid_q <= 1'b0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: if (rsp_valid_i) begin
          // Written after the read-clear so a coincident completion wins.
          status_q[CMDR_DON] <= ~any_flag;
          status_q[CMDR_NAK] <= rsp_nak_i;
          status_q[CMDR_AL]  <= rsp_al_i;
          status_q[CMDR_ERR] <= rsp_err_i;
          bc_q               <= 1'b0;
          if (is_read_cmd(cmd_q)) rx_q <= rx_byte_i;
          if (rsp_al_i) bb_q <= 1'b0;
          else if (!any_flag && cmd_q == CMD_START) bb_q <= 1'b1;
          else if (!any_flag && cmd_q == CMD_STOP) bb_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_LOCAL: begin
          if (!bb_q && ({1'b0, tx_q} < NUM_BUSES_W)) begin
            bus_id_q           <= tx_q[3:0];
            status_q[CMDR_DON] <= 1'b1;
          end else begin
            status_q[CMDR_ERR] <= 1'b1;
          end
          bc_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_DISABLED;
      endcase

      if (wr_csr && !dat_i[CSR_E]) begin
        state_q     <= ST_DISABLED;
        cmd_valid_q <= 1'b0;
        bb_q        <= 1'b0;
        bc_q        <= 1'b0;
        status_q    <= 4'h0;
      end
    end
  end

  assign irq_o       = irq_q;
  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign tx_byte_o   = tx_snap_q;
  assign bus_id_o    = bus_id_q;

endmodule

// File: tb/tb_wb_cmd_responder.sv
// Directed bench for wb_cmd_responder: WB register access, SET_BUS, engine
// handshake and completions, abort via CSR and asynchronous reset.
module tb_wb_cmd_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] wdat;
  logic [7:0] rdat;
  logic       ack, irq;
  logic [2:0] cmd;
  logic       cmd_valid, cmd_ready;
  logic [7:0] tx_byte;
  logic [3:0] bus_id;
  logic       rsp_valid, rsp_nak, rsp_al, rsp_err;
  logic [7:0] rx_byte;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  wb_cmd_responder #(.NUM_BUSES(16), .RESET_BUS_ID(0)) dut (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(wdat), .dat_o(rdat), .ack_o(ack), .irq_o(irq),
    .cmd_o(cmd), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .tx_byte_o(tx_byte), .bus_id_o(bus_id), .rsp_valid_i(rsp_valid),
    .rsp_nak_i(rsp_nak), .rsp_al_i(rsp_al), .rsp_err_i(rsp_err),
    .rx_byte_i(rx_byte)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (cmd_valid && cmd_ready) hs_cnt <= hs_cnt + 1;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] q, output int lat);
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ack && lat < 4);
    checks++;
    if (!ack) begin
      errors++;
      $display("FAIL wb_ack_timeout adr=%0d got no ack expected ack within 4 cycles", a);
    end
    q = rdat;
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL wb_ack_width adr=%0d got ack=%b expected 0", a, ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    int lat;
    wb_xfer(1'b1, a, d, q, lat);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [7:0] q);
    int lat;
    wb_xfer(1'b0, a, 8'h00, q, lat);
  endtask

  task automatic pulse_rsp(input logic n, input logic al, input logic er, input logic [7:0] rx);
    rsp_valid = 1'b1; rsp_nak = n; rsp_al = al; rsp_err = er; rx_byte = rx;
    step(1);
    rsp_valid = 1'b0; rsp_nak = 1'b0; rsp_al = 1'b0; rsp_err = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] exp_r [4];
    logic [7:0] q;
    int lat;
    exp_r = '{8'h00, 8'h00, 8'h00, 8'h00};
    checks++;
    if ({ack, irq, cmd_valid, cmd, tx_byte, bus_id, rdat} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b irq=%b vld=%b cmd=%b tx=%h bus=%h dat=%h expected all 0",
               ack, irq, cmd_valid, cmd, tx_byte, bus_id, rdat);
    end
    for (int r = 0; r < 4; r++) begin
      wb_xfer(1'b0, 2'(r), 8'h00, q, lat);
      checks++;
      if (q !== exp_r[r] || lat != 1) begin
        errors++;
        $display("FAIL reset_read reg=%0d got %h lat=%0d expected %h lat=1", r, q, lat, exp_r[r]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step(1);
      seen[3-i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    checks++;
    if (seen !== 4'b1010) begin
      errors++;
      $display("FAIL back_to_back_ack got %b expected 1010", seen);
    end
    step(1);
  endtask

  task automatic test_set_bus();
    logic [7:0] q;
    int vld_seen = 0;
    wb_write(2'b00, 8'hC0);
    wb_write(2'b01, 8'h05);
    wb_write(2'b10, 8'h06);
    for (int i = 0; i < 3; i++) begin
      if (cmd_valid) vld_seen++;
      step(1);
    end
    checks++;
    if (vld_seen != 0 || bus_id !== 4'h5 || irq !== 1'b1) begin
      errors++;
      $display("FAIL set_bus_ok got vld=%0d bus=%h irq=%b expected vld=0 bus=5 irq=1", vld_seen, bus_id, irq);
    end
    wb_read(2'b10, q);
    checks++;
    if (q !== 8'h86) begin
      errors++;
      $display("FAIL set_bus_cmdr got %h expected 86", q);
    end
    step(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got %b expected 0", irq);
    end
    wb_write(2'b01, 8'h10);
    wb_write(2'b10, 8'h06);
    step(2);
    wb_read(2'b10, q);
    checks++;
    if (q !== 8'h16 || bus_id !== 4'h5) begin
      errors++;
      $display("FAIL set_bus_range got cmdr=%h bus=%h expected cmdr=16 bus=5", q, bus_id);
    end
  endtask

  task automatic test_start();
    logic [7:0] q;
    int vcnt = 0;
    cmd_ready = 1'b0;
    wb_write(2'b10, 8'h04);
    for (int i = 0; i < 3; i++) begin
      if (cmd_valid && cmd === 3'b100) vcnt++;
      step(1);
    end
    cmd_ready = 1'b1;
    if (cmd_valid && cmd === 3'b100) vcnt++;
    step(1);
    cmd_ready = 1'b0;
    checks++;
    if (vcnt != 4 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_issue got valid_cycles=%0d vld_after=%b expected 4 and 0", vcnt, cmd_valid);
    end
    pulse_rsp(1'b0, 1'b0, 1'b0, 8'h00);
    wb_read(2'b00, q);
    checks++;
    if (q !== 8'hE5) begin
      errors++;
      $display("FAIL start_csr got %h expected E5", q);
    end
    wb_read(2'b10, q);
    checks++;
    if (q !== 8'h84) begin
      errors++;
      $display("FAIL start_cmdr got %h expected 84", q);
    end
  endtask

  task automatic test_set_bus_busy();
    logic [7:0] q;
    wb_write(2'b01, 8'h03);
    wb_write(2'b10, 8'h06);
    step(2);
    wb_read(2'b10, q);
    checks++;
    if (q !== 8'h16 || bus_id !== 4'h5) begin
      errors++;
      $display("FAIL set_bus_busy got cmdr=%h bus=%h expected cmdr=16 bus=5", q, bus_id);
    end
  endtask

  task automatic test_write_nak();
    logic [7:0] q;
    cmd_ready = 1'b0;
    wb_write(2'b01, 8'hA5);
    wb_write(2'b10, 8'h01);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 3'b001 || tx_byte !== 8'hA5) begin
      errors++;
      $display("FAIL write_issue got vld=%b cmd=%b tx=%h expected 1 001 a5", cmd_valid, cmd, tx_byte);
    end
    wb_write(2'b01, 8'h5A);
    checks++;
    if (cmd_valid !== 1'b1 || tx_byte !== 8'hA5) begin
      errors++;
      $display("FAIL tx_snapshot got vld=%b tx=%h expected 1 a5", cmd_valid, tx_byte);
    end
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    pulse_rsp(1'b1, 1'b0, 1'b0, 8'h00);
    wb_read(2'b10, q);
    checks++;
    if (q !== 8'h41) begin
      errors++;
      $display("FAIL write_nak_cmdr got %h expected 41", q);
    end
  endtask

  task automatic test_read_byte();
    logic [7:0] q;
    int hs0;
    hs0 = hs_cnt;
    cmd_ready = 1'b1;
    wb_write(2'b10, 8'h02);
    step(1);
    wb_write(2'b10, 8'h01);
    step(2);
    pulse_rsp(1'b0, 1'b0, 1'b0, 8'h3C);
    step(2);
    cmd_ready = 1'b0;
    checks++;
    if (hs_cnt - hs0 != 1) begin
      errors++;
      $display("FAIL read_handshakes got %0d expected 1", hs_cnt - hs0);
    end
    wb_read(2'b01, q);
    checks++;
    if (q !== 8'h3C) begin
      errors++;
      $display("FAIL read_dpr got %h expected 3c", q);
    end
    wb_read(2'b10, q);
    checks++;
    if (q !== 8'h82) begin
      errors++;
      $display("FAIL read_cmdr got %h expected 82", q);
    end
  endtask

  task automatic test_abort_and_reset();
    logic [7:0] q;
    cmd_ready = 1'b1;
    wb_write(2'b10, 8'h05);
    step(1);
    cmd_ready = 1'b0;
    wb_write(2'b00, 8'h00);
    wb_read(2'b11, q);
    checks++;
    if (q !== 8'h00) begin
      errors++;
      $display("FAIL abort_state got %h expected 00", q);
    end
    pulse_rsp(1'b1, 1'b0, 1'b0, 8'h77);
    step(2);
    wb_read(2'b10, q);
    checks++;
    if (q !== 8'h05 || irq !== 1'b0) begin
      errors++;
      $display("FAIL abort_cmdr got cmdr=%h irq=%b expected cmdr=05 irq=0", q, irq);
    end
    wb_read(2'b00, q);
    checks++;
    if (q !== 8'h05) begin
      errors++;
      $display("FAIL abort_csr got %h expected 05", q);
    end
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'b00;
    step(1);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_ack got %b expected 1", ack);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || cmd_valid !== 1'b0 || bus_id !== 4'h0) begin
      errors++;
      $display("FAIL async_reset got ack=%b vld=%b bus=%h expected 0 0 0", ack, cmd_valid, bus_id);
    end
    cyc = 1'b0; stb = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'b00; wdat = 8'h00;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nak = 1'b0; rsp_al = 1'b0; rsp_err = 1'b0;
    rx_byte = 8'h00;
    step(3);
    rst_n = 1'b1;
    step(1);
    test_reset();
    test_back_to_back();
    test_set_bus();
    test_start();
    test_set_bus_busy();
    test_write_nak();
    test_read_byte();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
